master_timer: RTL
=================

// Module: master_timer
// PURPOSE
//  I2C master-side bus timer: generates SCL and START/STOP/repeated-START
//  SDA sequencing, and clocks 9-bit frames (8 data + ACK) per command.
//  Supplies setup/sample strobes and the bit index to the master shift
//  register, which owns SDA during data phases.
//  Counterpart of the slave bit timer; sits between the APB register block
//  and the open-drain pad drivers.
// PARAMETERS
//  DIV_WIDTH  10  width of clk_div; one SCL half-period = clk_div clk cycles
// PORTS
//  clk          in   1          system clock
//  n_rst        in   1          asynchronous reset, active-low
//  clk_div      in   DIV_WIDTH  half-period length in clk cycles; values <2 treated as 2
//  cmd_valid    in   1          command request
//  cmd_op       in   2          0=START 1=BYTE 2=STOP 3=RSTART (cmd_op_t)
//  cmd_ready    out  1          command accepted when cmd_valid & cmd_ready
//  cmd_err      out  1          1-cycle pulse: illegal command, ignored
//  scl_in       in   1          raw SCL pad input (used only with CLK_STRETCH_EN)
//  scl_low      out  1          1 = pull SCL low; 0 = release
//  sda_ovr_en   out  1          1 = timer owns SDA (START/STOP/RSTART/hold)
//  sda_ovr_val  out  1          SDA value while sda_ovr_en (0 = pull low)
//  setup_strobe out  1          1-cycle pulse on the first cycle of each SCL-low bit phase
//  sample_strobe out 1          1-cycle pulse on the last cycle of each SCL-high bit phase
//  bit_idx      out  4          current bit 0..8 (8 = ACK slot)
//  ack_phase    out  1          high while bit_idx==8 in BIT_LOW/BIT_HIGH
//  byte_done    out  1          1-cycle pulse when a BYTE frame completes
//  busy         out  1          high in every state except IDLE and HOLD
// BEHAVIOUR
//  - Reset: state=IDLE; scl_low=0, sda_ovr_en=0, sda_ovr_val=1, cmd_ready=1,
//    all strobes/cmd_err/byte_done=0, bit_idx=0, ack_phase=0, busy=0.
//    Reset mid-operation releases both lines immediately.
//  - Outputs are registered, decoded from next_state; they change on the
//    same edge as state.
//  - clk_div is latched at command accept; each phase below lasts exactly
//    D cycles (D = max(clk_div,2)).
//  - Phase counter: loads D-1 on phase entry, decrements, ends the phase at 0.
//  - cmd_ready=1 only in IDLE and HOLD. START is legal only in IDLE.
//    BYTE, STOP and RSTART are legal only in HOLD.
//    Any other accepted combination -> cmd_err pulse next cycle; no state change.
//  - Phase table (state: scl_low/sda_ovr_en/sda_ovr_val):
//    IDLE:0/0/1
//    START_A:0/1/1 -> START_B:0/1/0 -> START_C:1/1/0 -> HOLD:1/0/1
//    BYTE: 9 x (BIT_LOW:1/0/- then BIT_HIGH:0/0/-)
//      bit_idx increments when BIT_HIGH ends; after bit 8 -> HOLD,
//      byte_done pulses, bit_idx returns to 0.
//    STOP: STOP_A:1/1/0 -> STOP_B:0/1/0 -> STOP_C:0/1/1 -> IDLE
//    RSTART: RS_A:1/1/1 -> RS_B:0/1/1 -> START_B -> START_C -> HOLD
//  - SDA never changes on the same edge SCL changes.
//    Transitions START_B->START_C and STOP_A->STOP_B change only SCL.
//  - START latency: 3D cycles to HOLD. BYTE: 18D cycles. STOP: 3D. RSTART: 4D.
//  - HOLD persists indefinitely with SCL low (clock held) until the next command.
// CONFIGURATION
//  Macro CLK_STRETCH_EN:
//  - Defined: scl_in passes through a 2-flop synchronizer. In BIT_HIGH,
//    STOP_B, RS_B and START_A the counter is frozen while synced SCL reads 0,
//    so a slave can stretch the clock. Strobes are not emitted while frozen.
//  - Undefined: scl_in ignored; all phases are a fixed D cycles.
// STRUCTURE
//  - Package i2c_master_pkg: cmd_op_t enum (CMD_START, CMD_BYTE, CMD_STOP,
//    CMD_RSTART); mt_state_t enum (IDLE, START_A, START_B, START_C, HOLD,
//    BIT_LOW, BIT_HIGH, STOP_A, STOP_B, STOP_C, RS_A, RS_B); const LAST_BIT=8.
//  - Sub-module master_scl_sync (2-flop synchronizer), instantiated only
//    under CLK_STRETCH_EN.
// TESTING
//  1. Reset asserted mid-BYTE -> same cycle: scl_low=0, sda_ovr_en=0, cmd_ready=1, bit_idx=0.
//  2. clk_div=4, START in IDLE -> SDA low after 4 cycles, SCL low after 8,
//     HOLD (cmd_ready=1) at cycle 12.
//  3. clk_div=4, BYTE -> 9 setup_strobes 8 cycles apart; sample_strobe 7 cycles
//     after each; ack_phase only on bit 8; byte_done at cycle 72.
//  4. STOP from HOLD, clk_div=4 -> SCL released at 4, SDA released at 8
//     with SCL high, IDLE at 12.
//  5. BYTE in IDLE -> cmd_err pulse, state stays IDLE.
//     clk_div=0 -> START takes 6 cycles.
//  6. With CLK_STRETCH_EN, scl_in held low 10 cycles in BIT_HIGH -> that
//     phase extends by 10 cycles (plus sync delay).
//     Without the macro -> timing unchanged.

Source files
------------

// File: rtl/i2c_master_pkg.sv
// Shared types for the I2C master bus timer: command opcodes, timer states
// and the per-state SCL/SDA line drive table.
package i2c_master_pkg;

   typedef enum logic [1:0] {
      CMD_START  = 2'd0,
      CMD_BYTE   = 2'd1,
      CMD_STOP   = 2'd2,
      CMD_RSTART = 2'd3
   } cmd_op_t;

   typedef enum logic [3:0] {
      IDLE, START_A, START_B, START_C, HOLD, BIT_LOW, BIT_HIGH,
      STOP_A, STOP_B, STOP_C, RS_A, RS_B
   } mt_state_t;

   localparam logic [3:0] LAST_BIT = 4'd8;

   typedef struct packed {
      logic scl_low;
      logic sda_en;
      logic sda_val;
   } line_drive_t;

   // Pad drive per state; bit phases leave SDA to the shift register.
   function automatic line_drive_t line_drive(input mt_state_t s);
      line_drive_t d;
      case (s)
         START_A:  d = 3'b011;
         START_B:  d = 3'b010;
         START_C:  d = 3'b110;
         HOLD:     d = 3'b101;
         BIT_LOW:  d = 3'b101;
         BIT_HIGH: d = 3'b001;
         STOP_A:   d = 3'b110;
         STOP_B:   d = 3'b010;
         STOP_C:   d = 3'b011;
         RS_A:     d = 3'b111;
         RS_B:     d = 3'b011;
         default:  d = 3'b001;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/master_scl_sync.sv
// Two-flop synchronizer for the raw SCL pad input; resets to the idle-high
// bus level so a fresh reset never looks like a stretched clock.
module master_scl_sync (
   input  logic clk,
   input  logic n_rst,
   input  logic i_scl,
   output logic o_scl
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_scl;
         r_sync <= r_meta;
      end
   end

   assign o_scl = r_sync;

endmodule

// File: rtl/master_timer.sv
// I2C master bus timer: SCL generation, START/STOP/RSTART sequencing and
// 9-bit byte framing. Build option CLK_STRETCH_EN enables slave clock stretching.
module master_timer
   import i2c_master_pkg::*;
#(
   parameter int DIV_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [DIV_WIDTH-1:0] clk_div,
   input  logic                 cmd_valid,
   input  logic [1:0]           cmd_op,
   output logic                 cmd_ready,
   output logic                 cmd_err,
   input  logic                 scl_in,
   output logic                 scl_low,
   output logic                 sda_ovr_en,
   output logic                 sda_ovr_val,
   output logic                 setup_strobe,
   output logic                 sample_strobe,
   output logic [3:0]           bit_idx,
   output logic                 ack_phase,
   output logic                 byte_done,
   output logic                 busy
);

   mt_state_t             r_state, w_next_state;
   cmd_op_t               w_op;
   logic [DIV_WIDTH-1:0]  w_div_in, r_div, r_cnt, w_next_cnt, w_load_val;
   logic [3:0]            r_bit_idx, w_next_bit;
   logic                  w_accept, w_freeze, w_phase_end;
   logic                  w_err, w_done, w_sample, w_next_rest;
   line_drive_t           w_drive;

   assign w_op     = cmd_op_t'(cmd_op);
   assign w_div_in = (clk_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : clk_div;

`ifdef CLK_STRETCH_EN
   logic w_scl_sync;

   master_scl_sync u_scl_sync (
      .clk   (clk),
      .n_rst (n_rst),
      .i_scl (scl_in),
      .o_scl (w_scl_sync)
   );

   // A slave holding SCL low freezes only the phases where SCL is released.
   assign w_freeze = ~w_scl_sync & (r_state inside {BIT_HIGH, STOP_B, RS_B, START_A});
`else
   logic w_unused_scl;
   assign w_unused_scl = scl_in;
   assign w_freeze     = 1'b0;
`endif

   assign w_accept    = cmd_valid & cmd_ready;
   assign w_phase_end = (r_cnt == '0) & ~w_freeze;
   // The first phase of a command uses the divider being latched on this edge.
   assign w_load_val  = (w_accept ? w_div_in : r_div) - DIV_WIDTH'(1);

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_next_bit   = r_bit_idx;
      w_err        = 1'b0;
      w_done       = 1'b0;
      if (!w_freeze && r_cnt != '0) w_next_cnt = r_cnt - DIV_WIDTH'(1);

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_op == CMD_START) w_next_state = START_A;
               else                   w_err        = 1'b1;
            end
         end
         HOLD: begin
            if (w_accept) begin
               case (w_op)
                  CMD_BYTE:   w_next_state = BIT_LOW;
                  CMD_STOP:   w_next_state = STOP_A;
                  CMD_RSTART: w_next_state = RS_A;
                  default:    w_err        = 1'b1;
               endcase
            end
         end
         START_A:  if (w_phase_end) w_next_state = START_B;
         START_B:  if (w_phase_end) w_next_state = START_C;
         START_C:  if (w_phase_end) w_next_state = HOLD;
         BIT_LOW:  if (w_phase_end) w_next_state = BIT_HIGH;
         BIT_HIGH: begin
            if (w_phase_end) begin
               if (r_bit_idx == LAST_BIT) begin
                  w_next_state = HOLD;
                  w_next_bit   = 4'd0;
                  w_done       = 1'b1;
               end else begin
                  w_next_state = BIT_LOW;
                  w_next_bit   = r_bit_idx + 4'd1;
               end
            end
         end
         STOP_A:   if (w_phase_end) w_next_state = STOP_B;
         STOP_B:   if (w_phase_end) w_next_state = STOP_C;
         STOP_C:   if (w_phase_end) w_next_state = IDLE;
         RS_A:     if (w_phase_end) w_next_state = RS_B;
         RS_B:     if (w_phase_end) w_next_state = START_B;
         default:  w_next_state = IDLE;
      endcase

      w_next_rest = (w_next_state == IDLE) || (w_next_state == HOLD);
      if (w_next_state != r_state) w_next_cnt = w_next_rest ? '0 : w_load_val;
   end

   // Last cycle of SCL-high is the one following the 1->0 counter step.
   assign w_sample = (r_state == BIT_HIGH) && (r_cnt == DIV_WIDTH'(1)) && !w_freeze;
   assign w_drive  = line_drive(w_next_state);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_div         <= DIV_WIDTH'(2);
         r_bit_idx     <= 4'd0;
         scl_low       <= 1'b0;
         sda_ovr_en    <= 1'b0;
         sda_ovr_val   <= 1'b1;
         cmd_ready     <= 1'b1;
         cmd_err       <= 1'b0;
         setup_strobe  <= 1'b0;
         sample_strobe <= 1'b0;
         ack_phase     <= 1'b0;
         byte_done     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_cnt         <= w_next_cnt;
         r_bit_idx     <= w_next_bit;
         if (w_accept) r_div <= w_div_in;
         scl_low       <= w_drive.scl_low;
         sda_ovr_en    <= w_drive.sda_en;
         sda_ovr_val   <= w_drive.sda_val;
         cmd_ready     <= w_next_rest;
         busy          <= ~w_next_rest;
         cmd_err       <= w_err;
         setup_strobe  <= (w_next_state == BIT_LOW) && (r_state != BIT_LOW);
         sample_strobe <= w_sample;
         ack_phase     <= (w_next_bit == LAST_BIT) &&
                          ((w_next_state == BIT_LOW) || (w_next_state == BIT_HIGH));
         byte_done     <= w_done;
      end
   end

   assign bit_idx = r_bit_idx;

endmodule
